lane_vreg_access_seq: RTL and testbench
=======================================

// Module: lane_vreg_access_seq
// PURPOSE
// Per-lane vector register access sequencer feeding one crossbar_switch request port. Accepts one
// vector access command (read or write, register, base address, element count), then issues one
// element request per grant, holds each request stable until granted, and counts rsp_vld to report
// completion. One instance per lane; sits between lane execute control and the crossbar.
// PARAMETERS
// VREG_DEPTH  64  elements per vector register; AW = $clog2(VREG_DEPTH)
// VREG_WIDTH  32  element data width
// NUM_VREG    8   vector registers; RW = $clog2(NUM_VREG)
// PORTS
// clk           in   1          clock
// reset         in   1          synchronous, active-high reset
// cmd_vld       in   1          command valid
// cmd_rdy       out  1          command accepted when cmd_vld && cmd_rdy
// cmd_write     in   1          1 = WRITE_REQ, 0 = READ_REQ
// cmd_vreg      in   RW         target vector register
// cmd_base      in   AW         first element address
// cmd_len       in   AW+1       element count, 0..VREG_DEPTH
// wr_vld        in   1          write element available
// wr_data       in   VREG_WIDTH write element data
// wr_rdy        out  1          write element consumed when wr_vld && wr_rdy
// req_out       out  cntrl_req_t request to crossbar port (vld, vec_reg_ptr, addr, access_type, access_length, data)
// req_grant     in   1          crossbar reg_req_grant for this port
// rsp_vld       in   1          crossbar rsp_vld for this port
// rd_data       in   VREG_WIDTH register file read data, valid with rsp_vld on reads
// rd_out_vld    out  1          read element to lane
// rd_out_idx    out  AW         element index (0-based) of rd_out_data
// rd_out_data   out  VREG_WIDTH read element
// done          out  1          one-cycle pulse: command complete
// BEHAVIOUR
// - Reset: state IDLE; cmd_rdy=0 during reset cycle, 1 after; req_out all-zero (vld=0); wr_rdy=0;
//   rd_out_vld=0, rd_out_idx=0, rd_out_data=0; done=0; all counters 0. Reset mid-command aborts it, no done.
// - FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE. cmd_rdy=1 only in IDLE.
// - IDLE: on accept latch cmd fields; issue_cnt=rsp_cnt=0. cmd_len==0 -> DONE directly (no requests).
// - ISSUE: req_out.vld=1 for reads every cycle; for writes only once wr_data latched into req holding reg.
//   addr = (cmd_base + issue_cnt) mod VREG_DEPTH (natural AW-bit wrap); access_length = cmd_len - issue_cnt;
//   vec_reg_ptr = cmd_vreg. All req_out fields stable while vld=1 and grant=0.
// - Grant: req_grant && req_out.vld -> issue_cnt++; next element presented next cycle (1 req/cycle max under
//   back-to-back grants). req_grant with vld=0 ignored. issue_cnt==cmd_len after grant -> DRAIN, vld=0.
// - Write data: wr_rdy=1 when holding reg empty or being granted this cycle (skid-free refill, no bubble).
//   wr_rdy=0 outside ISSUE and once cmd_len elements taken.
// - rsp_vld (arrives 1 cycle after grant): rsp_cnt++ in ISSUE or DRAIN; rsp_vld in IDLE/DONE ignored.
//   Reads: next cycle rd_out_vld=1, rd_out_idx=rsp_cnt(pre-increment), rd_out_data=rd_data.
// - DRAIN: wait rsp_cnt==cmd_len (may already hold on entry) -> DONE. Grant and last rsp same cycle counted both.
// - DONE: done=1 for exactly one cycle, then IDLE (cmd_rdy=1). Min command-to-command gap: 1 cycle.
// - Counters AW+1 bits so cmd_len=VREG_DEPTH does not overflow.
// TESTING
// 1 Read vreg3 base 0 len 4, grant held high -> addr 0,1,2,3 on consecutive cycles, 4 rd_out with idx 0..3, done 1 cycle after last rd_out.
// 2 Write vreg1 base 62 len 4, wr_vld always 1 -> addr 62,63,0,1; data in order; access_length 4,3,2,1.
// 3 Read len 3, grant low 5 cycles then high -> req_out unchanged for 5 cycles, no issue_cnt advance.
// 4 Write len 2 with wr_vld gap of 3 cycles -> req_out.vld low during gap, no spurious grant effect.
// 5 cmd_len 0 -> no req_out.vld, done pulse 2 cycles after accept; cmd_len 64 -> 64 rsp then done.
// 6 reset asserted mid-ISSUE -> next cycle all outputs zero, no done; new command accepted normally.

Source files
------------

// File: rtl/lane_vreg_access_seq.sv
// Per-lane vector register access sequencer: turns one vector command
// into a stream of element requests toward one crossbar port.
package lane_vreg_pkg;
  localparam int VREG_DEPTH = 64;
  localparam int VREG_WIDTH = 32;
  localparam int NUM_VREG   = 8;
  localparam int AW = $clog2(VREG_DEPTH);
  localparam int RW = $clog2(NUM_VREG);

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_t;

  typedef struct packed {
    logic                  vld;
    logic [RW-1:0]         vec_reg_ptr;
    logic [AW-1:0]         addr;
    access_t               access_type;
    logic [AW:0]           access_length;
    logic [VREG_WIDTH-1:0] data;
  } cntrl_req_t;
endpackage

module lane_vreg_access_seq
  import lane_vreg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_write,
  input  logic [RW-1:0]         cmd_vreg,
  input  logic [AW-1:0]         cmd_base,
  input  logic [AW:0]           cmd_len,
  input  logic                  wr_vld,
  input  logic [VREG_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  output cntrl_req_t            req_out,
  input  logic                  req_grant,
  input  logic                  rsp_vld,
  input  logic [VREG_WIDTH-1:0] rd_data,
  output logic                  rd_out_vld,
  output logic [AW-1:0]         rd_out_idx,
  output logic [VREG_WIDTH-1:0] rd_out_data,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t                state, state_n;
  logic                  wr_q;
  logic [RW-1:0]         vreg_q;
  logic [AW-1:0]         base_q;
  logic [AW:0]           len_q;
  logic [AW:0]           issue_cnt;
  logic [AW:0]           issue_inc;
  logic [AW:0]           rsp_cnt;
  logic [AW:0]           rsp_cnt_n;
  logic                  hold_vld;
  logic [VREG_WIDTH-1:0] hold_data;
  logic                  accept;
  logic                  req_vld;
  logic                  fire;
  logic                  last_fire;
  logic                  take;
  logic                  rsp_ok;

  assign cmd_rdy   = (state == IDLE) && !reset;
  assign accept    = cmd_vld && cmd_rdy;
  assign req_vld   = (state == ISSUE) && (!wr_q || hold_vld);
  assign fire      = req_vld && req_grant;
  assign issue_inc = issue_cnt + ONE;
  assign last_fire = fire && (issue_inc == len_q);
  assign rsp_ok    = rsp_vld && ((state == ISSUE) || (state == DRAIN));
  assign rsp_cnt_n = rsp_cnt + {{AW{1'b0}}, rsp_ok};

  // Refill the holding reg in the same cycle it is granted away.
  assign wr_rdy = (state == ISSUE) && wr_q &&
                  (hold_vld ? (fire && !last_fire)
                            : (issue_cnt < len_q));
  assign take   = wr_vld && wr_rdy;

  always_comb begin
    req_out = '0;
    if (req_vld) begin
      req_out.vld           = 1'b1;
      req_out.vec_reg_ptr   = vreg_q;
      req_out.addr          = base_q + issue_cnt[AW-1:0];
      req_out.access_type   = wr_q ? WRITE_REQ : READ_REQ;
      req_out.access_length = len_q - issue_cnt;
      req_out.data          = wr_q ? hold_data : '0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = (cmd_len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (last_fire)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (rsp_cnt_n == len_q)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q        <= 1'b0;
      vreg_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt   <= '0;
      rsp_cnt     <= '0;
      hold_vld    <= 1'b0;
      hold_data   <= '0;
      rd_out_vld  <= 1'b0;
      rd_out_idx  <= '0;
      rd_out_data <= '0;
      done        <= 1'b0;
    end else begin
      done       <= (state == DONE);
      rd_out_vld <= 1'b0;
      if (accept) begin
        wr_q      <= cmd_write;
        vreg_q    <= cmd_vreg;
        base_q    <= cmd_base;
        len_q     <= cmd_len;
        issue_cnt <= '0;
        rsp_cnt   <= '0;
        hold_vld  <= 1'b0;
      end
      if (fire)
        issue_cnt <= issue_inc;
      if (take) begin
        hold_vld  <= 1'b1;
        hold_data <= wr_data;
      end else if (fire) begin
        hold_vld  <= 1'b0;
      end
      if (rsp_ok) begin
        rsp_cnt <= rsp_cnt_n;
        if (!wr_q) begin
          rd_out_vld  <= 1'b1;
          rd_out_idx  <= rsp_cnt[AW-1:0];
          rd_out_data <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_vreg_access_seq.sv
// Bench for lane_vreg_access_seq: directed and random commands
// against a per-element transaction model of the crossbar port.
module tb_lane_vreg_access_seq;
  import lane_vreg_pkg::*;

  localparam int DEPTH = VREG_DEPTH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cmd_vld, cmd_rdy, cmd_write;
  logic [RW-1:0]         cmd_vreg;
  logic [AW-1:0]         cmd_base;
  logic [AW:0]           cmd_len;
  logic                  wr_vld, wr_rdy;
  logic [VREG_WIDTH-1:0] wr_data;
  cntrl_req_t            req_out;
  logic                  req_grant, rsp_vld;
  logic [VREG_WIDTH-1:0] rd_data;
  logic                  rd_out_vld;
  logic [AW-1:0]         rd_out_idx;
  logic [VREG_WIDTH-1:0] rd_out_data;
  logic                  done;

  lane_vreg_access_seq dut (
    .clk(clk), .reset(reset),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_write(cmd_write), .cmd_vreg(cmd_vreg),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .req_out(req_out), .req_grant(req_grant),
    .rsp_vld(rsp_vld), .rd_data(rd_data),
    .rd_out_vld(rd_out_vld), .rd_out_idx(rd_out_idx),
    .rd_out_data(rd_out_data), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // stimulus controls
  int c_vreg, c_base, c_len;
  bit c_write, cmd_pend;
  int gmode, wmode, g_from, w_lo, w_hi;

  // reference model state
  bit busy, m_write, rsp_next, hold_prev;
  int m_vreg, m_base, m_len, acc_cyc, done_at;
  int issued, taken, rsps;
  logic [VREG_WIDTH-1:0] wq[$];
  cntrl_req_t prev_req;
  bit exp_rd_vld;
  int exp_rd_idx;
  logic [VREG_WIDTH-1:0] exp_rd_data;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic g, ev, ewr, fire, in_iss;
    @(negedge clk);
    cyc++;
    cmd_vld   = cmd_pend;
    cmd_write = c_write;
    cmd_vreg  = RW'(c_vreg);
    cmd_base  = AW'(c_base);
    cmd_len   = (AW+1)'(c_len);
    rsp_vld   = rsp_next;
    rd_data   = $urandom;
    case (gmode)
      0:       g = 1'b1;
      1:       g = 1'($urandom_range(0, 1));
      default: g = (cyc >= g_from);
    endcase
    req_grant = g;
    case (wmode)
      0:       wr_vld = 1'b1;
      1:       wr_vld = 1'($urandom_range(0, 1));
      default: wr_vld = !(cyc >= w_lo && cyc < w_hi);
    endcase
    wr_data = $urandom;
    #1;
    if (busy && cyc == done_at) busy = 0;
    in_iss = busy && cyc > acc_cyc && issued < m_len;
    ev     = in_iss && (!m_write || taken > issued);
    fire   = ev && g;
    ewr    = m_write && in_iss && taken < m_len &&
             (taken == issued || fire);
    chk("cmd_rdy", cmd_rdy, !busy);
    chk("req_vld", req_out.vld, ev);
    if (ev) begin
      chk("req_addr", req_out.addr, (m_base + issued) % DEPTH);
      chk("req_len", req_out.access_length, m_len - issued);
      chk("req_vreg", req_out.vec_reg_ptr, m_vreg);
      chk("req_type", req_out.access_type, m_write);
      chk("req_data", req_out.data, m_write ? wq[issued] : '0);
      if (hold_prev) chk("req_stable", req_out, prev_req);
    end else begin
      chk("req_zero", req_out, '0);
    end
    chk("wr_rdy", wr_rdy, ewr);
    chk("rd_vld", rd_out_vld, exp_rd_vld);
    if (exp_rd_vld) begin
      chk("rd_idx", rd_out_idx, exp_rd_idx);
      chk("rd_data", rd_out_data, exp_rd_data);
    end
    chk("done", done, cyc == done_at);
    hold_prev  = ev && !g;
    prev_req   = req_out;
    exp_rd_vld = 0;
    if (rsp_vld && busy) begin
      rsps++;
      if (!m_write) begin
        exp_rd_vld  = 1;
        exp_rd_idx  = rsps - 1;
        exp_rd_data = rd_data;
      end
      if (rsps == m_len) done_at = cyc + 2;
    end
    if (wr_vld && ewr) begin
      wq.push_back(wr_data);
      taken++;
    end
    if (fire) issued++;
    rsp_next = fire;
    if (cmd_pend && !busy) begin
      busy     = 1;
      cmd_pend = 0;
      m_write  = c_write;
      m_vreg   = c_vreg;
      m_base   = c_base;
      m_len    = c_len;
      acc_cyc  = cyc;
      issued   = 0;
      taken    = 0;
      rsps     = 0;
      wq.delete();
      done_at  = (c_len == 0) ? cyc + 2 : -1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    reset     = 1'b1;
    cmd_vld   = 1'b0;
    wr_vld    = 1'b0;
    req_grant = 1'b0;
    rsp_vld   = 1'b0;
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    busy = 0; cmd_pend = 0; rsp_next = 0;
    hold_prev = 0; exp_rd_vld = 0; done_at = -1;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_rdy", cmd_rdy, 1'b1);
    chk("post_rst_req", req_out, '0);
    chk("post_rst_wr_rdy", wr_rdy, 1'b0);
    chk("post_rst_rd_vld", rd_out_vld, 1'b0);
    chk("post_rst_rd_idx", rd_out_idx, '0);
    chk("post_rst_rd_data", rd_out_data, '0);
    chk("post_rst_done", done, 1'b0);
  endtask

  task automatic run_cmd(bit w, int vreg, int base, int len,
                         int gm, int wm, int glow, int wlo, int whi);
    int n;
    c_write = w; c_vreg = vreg; c_base = base; c_len = len;
    gmode = gm; wmode = wm;
    g_from = cyc + 2 + glow;
    w_lo   = cyc + 1 + wlo;
    w_hi   = cyc + 1 + whi;
    cmd_pend = 1;
    n = 0;
    while ((cmd_pend || busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_pend || busy) begin
      errors++;
      $error("FAIL cmd_timeout observed=busy expected=done cyc=%0d", cyc);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_vld = 0; cmd_write = 0; cmd_vreg = '0;
    cmd_base = '0; cmd_len = '0;
    wr_vld = 0; wr_data = '0; req_grant = 0;
    rsp_vld = 0; rd_data = '0;
    gmode = 0; wmode = 0;
    do_reset();
    run_cmd(0, 3, 0, 4, 0, 0, 0, 0, 0);
    run_cmd(1, 1, 62, 4, 0, 0, 0, 0, 0);
    run_cmd(0, 2, 5, 3, 2, 0, 5, 0, 0);
    run_cmd(1, 4, 10, 2, 0, 2, 0, 2, 5);
    run_cmd(0, 0, 7, 0, 0, 0, 0, 0, 0);
    run_cmd(1, 6, 0, 0, 1, 1, 0, 0, 0);
    run_cmd(1, 5, 33, 64, 1, 1, 0, 0, 0);
    run_cmd(0, 6, 1, 64, 0, 0, 0, 0, 0);
    c_write = 0; c_vreg = 2; c_base = 9; c_len = 20;
    gmode = 1; cmd_pend = 1;
    repeat (5) tick();
    do_reset();
    repeat (3) tick();
    run_cmd(0, 7, 20, 5, 0, 0, 0, 0, 0);
    c_write = 1; c_vreg = 1; c_base = 50; c_len = 20;
    gmode = 0; wmode = 0; cmd_pend = 1;
    repeat (6) tick();
    do_reset();
    run_cmd(1, 3, 60, 6, 1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 7),
              $urandom_range(0, 63), $urandom_range(0, 12),
              $urandom_range(0, 1), $urandom_range(0, 1),
              0, 0, 0);
    end
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
